// File: rtl/bus_pkg.sv
// Shared encodings for the CPU-side bus controller and its address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_decode.sv
// Combinational address decoder: maps a CPU byte address onto one slave select.
module bus_decode
  import bus_pkg::*;
#(
  parameter logic [31:0] MEM_TOP = 32'h0000_3000,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
  input  logic [31:0] addr_i,
  output sel_e        sel_o
);

  // RAM is checked first so an overlapping IO window can never shadow memory.
  always_comb begin
    sel_o = SEL_NONE;
    if (addr_i < MEM_TOP)                         sel_o = SEL_RAM;
    else if (addr_i[31:16] == IO_BASE[31:16])     sel_o = SEL_IO;
  end

endmodule

// File: rtl/bus_ctrl.sv
// picorv32 native-bus controller: decodes to RAM/IO, registers the response and
// completes unmapped or stalled accesses with ERR_DATA plus a sticky error flag.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] MEM_TOP = 32'h0000_3000,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int          TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        ram_enable,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        io_enable,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  state_e        state_q;
  sel_e          sel_q, sel_dec;
  logic [CW-1:0] cnt_q;
  logic          mem_ready_q, ram_en_q, io_en_q, bus_err_q;
  logic [31:0]   rdata_q, err_addr_q;
  logic          sel_ready, err_set;
  logic [31:0]   sel_rdata;

  // Write strobes/data and the fetch flag go straight to the slaves.
  logic unused_ok;
  assign unused_ok = ^{mem_instr, mem_wstrb, mem_wdata};

  bus_decode #(.MEM_TOP(MEM_TOP), .IO_BASE(IO_BASE)) u_dec (
    .addr_i (mem_addr),
    .sel_o  (sel_dec)
  );

  // Only the latched slave is listened to; the other one may be floating.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = ram_rdata;
    case (sel_q)
      SEL_RAM: sel_ready = ram_ready;
      SEL_IO: begin
        sel_ready = io_ready;
        sel_rdata = io_rdata;
      end
      default: ;
    endcase
  end

  assign err_set = ((state_q == ST_IDLE) && mem_valid && (sel_dec == SEL_NONE)) ||
                   ((state_q == ST_ACCESS) && mem_valid && !sel_ready && (cnt_q == CNT_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_NONE;
      cnt_q       <= '0;
      mem_ready_q <= 1'b0;
      ram_en_q    <= 1'b0;
      io_en_q     <= 1'b0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      // A new error outranks a clear arriving in the same cycle.
      if (err_set) begin
        bus_err_q  <= 1'b1;
        err_addr_q <= mem_addr;
      end else if (err_clr) begin
        bus_err_q  <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            if (sel_dec == SEL_NONE) begin
              rdata_q     <= ERR_DATA;
              mem_ready_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              sel_q    <= sel_dec;
              cnt_q    <= '0;
              ram_en_q <= (sel_dec == SEL_RAM);
              io_en_q  <= (sel_dec == SEL_IO);
              state_q  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!mem_valid) begin
            ram_en_q <= 1'b0;
            io_en_q  <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (sel_ready || (cnt_q == CNT_LAST)) begin
            rdata_q     <= sel_ready ? sel_rdata : ERR_DATA;
            mem_ready_q <= 1'b1;
            ram_en_q    <= 1'b0;
            io_en_q     <= 1'b0;
            state_q     <= ST_DONE;
          end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = rdata_q;
  assign ram_enable = ram_en_q;
  assign io_enable  = io_en_q;
  assign bus_err    = bus_err_q;
  assign err_addr   = err_addr_q;

endmodule
